// File: rtl/addsub_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : addsub_arb_pkg
// Brief  : Shared constants and types for the two-requester add/sub arbiter.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package addsub_arb_pkg;

  localparam int W    = 8;
  localparam int NREQ = 2;
  localparam int ID_W = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_t;

  typedef logic [ID_W-1:0] req_id_t;

endpackage
`default_nettype wire

// File: rtl/addsub_arb_addsub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : addsub
// Brief  : W-bit adder/subtractor, A+B or A-B (A+~B+1), with C/V/N/Z flags.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         c,
  output logic         v,
  output logic         n,
  output logic         z
);

  logic [W-1:0] b_eff;
  logic [W-2:0] s_lo;
  logic         s_msb;
  logic         c_into_msb;

  // Subtraction reuses the adder: invert B and inject the +1 as carry-in.
  assign b_eff = sub ? ~b : b;

  // Split at the MSB so the carry into the top bit is visible for overflow.
  assign {c_into_msb, s_lo} = {1'b0, a[W-2:0]} + {1'b0, b_eff[W-2:0]}
                              + {{(W-1){1'b0}}, sub};
  assign {c, s_msb} = {1'b0, a[W-1]} + {1'b0, b_eff[W-1]} + {1'b0, c_into_msb};

  assign s = {s_msb, s_lo};
  assign v = c_into_msb ^ c;
  assign n = s_msb;
  assign z = ~|s;

endmodule
`default_nettype wire

// File: rtl/addsub_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : addsub_arb
// Brief  : Round-robin arbiter sharing one addsub datapath between two
//          requesters; results returned with requester ID over valid/ready.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module addsub_arb #(
  parameter int NREQ = 2,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_m,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [W-1:0]      rsp_s,
  output logic              rsp_c,
  output logic              rsp_v,
  output logic              rsp_n,
  output logic              rsp_z,
  output logic              busy
);

  import addsub_arb_pkg::*;

  state_t        state;
  logic          last_grant;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          m_r;
  req_id_t       id_r;

  logic [NREQ-1:0] grant;
  logic            gnt_id;
  logic            handshake;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;

  logic [W-1:0]    alu_s;
  logic            alu_c;
  logic            alu_v;
  logic            alu_n;
  logic            alu_z;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign gnt_id    = grant[1];
  // Ready is offered only in IDLE and is forced low while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign handshake = |(req_valid & req_ready);
  assign a_sel     = gnt_id ? req_a[2*W-1:W] : req_a[W-1:0];
  assign b_sel     = gnt_id ? req_b[2*W-1:W] : req_b[W-1:0];
  assign busy      = (state != IDLE);

  addsub #(
    .W (W)
  ) u_addsub (
    .a   (a_r),
    .b   (b_r),
    .sub (m_r),
    .s   (alu_s),
    .c   (alu_c),
    .v   (alu_v),
    .n   (alu_n),
    .z   (alu_z)
  );

  // Sequencer: capture operands on grant, compute for one cycle, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_r        <= '0;
      b_r        <= '0;
      m_r        <= 1'b0;
      id_r       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_s      <= '0;
      rsp_c      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_n      <= 1'b0;
      rsp_z      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            a_r        <= a_sel;
            b_r        <= b_sel;
            m_r        <= req_m[gnt_id];
            id_r       <= gnt_id;
            last_grant <= gnt_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_s     <= alu_s;
          rsp_c     <= alu_c;
          rsp_v     <= alu_v;
          rsp_n     <= alu_n;
          rsp_z     <= alu_z;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_addsub_arb
// Brief  : Directed self-checking bench for addsub_arb with a result scoreboard.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_addsub_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_m;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_s;
  logic        rsp_c, rsp_v, rsp_n, rsp_z;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [12:0] sb_q[$];
  logic [12:0] obs_rsp;

  assign obs_rsp = {rsp_id, rsp_s, rsp_c, rsp_v, rsp_n, rsp_z};

  always #5 clk = ~clk;

  addsub_arb #(.NREQ(2), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_m     (req_m),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_c     (rsp_c),
    .rsp_v     (rsp_v),
    .rsp_n     (rsp_n),
    .rsp_z     (rsp_z),
    .busy      (busy)
  );

  // Reference arithmetic from sign-rule overflow, independent of carry chains.
  function automatic logic [12:0] model_rsp(input logic id, input logic [7:0] a,
                                            input logic [7:0] b, input logic m);
    logic [8:0] r;
    logic [7:0] s;
    logic       c, v;
    if (!m) begin
      r = {1'b0, a} + {1'b0, b};
      s = r[7:0];
      c = r[8];
      v = (a[7] == b[7]) && (s[7] != a[7]);
    end else begin
      r = {1'b0, a} + {1'b0, ~b} + 9'd1;
      s = r[7:0];
      c = r[8];
      v = (a[7] != b[7]) && (s[7] != a[7]);
    end
    return {id, s, c, v, s[7], (s == 8'h00)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [12:0] e;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk(tag, 32'(obs_rsp), 32'(e));
    end
  endtask

  task automatic set_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic m);
    if (id) begin
      req_a[15:8] = a; req_b[15:8] = b; req_m[1] = m;
    end else begin
      req_a[7:0] = a; req_b[7:0] = b; req_m[0] = m;
    end
  endtask

  task automatic wait_ready(input logic id, input string tag);
    int n = 0;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_seen"}, 32'(req_ready[id]), 32'd1);
  endtask

  // One isolated operation with rsp_ready held high.
  task automatic single_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                           input logic m, input string tag);
    @(negedge clk);
    set_op(id, a, b, m);
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    #1;
    wait_ready(id, tag);
    chk({tag, "_grant"}, 32'(req_ready), id ? 32'd2 : 32'd1);
    sb_q.push_back(model_rsp(id, a, b, m));
    @(negedge clk);
    req_valid[id] = 1'b0;
    chk({tag, "_exec"}, 32'({busy, rsp_valid, req_ready}), 32'b1000);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    pop_cmp(tag);
    @(negedge clk);
    chk({tag, "_idle"}, 32'({busy, rsp_valid}), 32'd0);
  endtask

  logic [7:0] ta [6];
  logic [7:0] tb_ [6];
  logic       tm [6];

  initial begin
    int cur [2];
    int grants, resps, n, pend;
    logic r;
    logic [12:0] held;

    ta[0] = 8'h05; tb_[0] = 8'hFB; tm[0] = 1'b0;
    ta[1] = 8'h80; tb_[1] = 8'h01; tm[1] = 1'b1;
    ta[2] = 8'hFF; tb_[2] = 8'hFF; tm[2] = 1'b0;
    ta[3] = 8'h00; tb_[3] = 8'h00; tm[3] = 1'b1;
    ta[4] = 8'h3C; tb_[4] = 8'h0A; tm[4] = 1'b0;
    ta[5] = 8'h01; tb_[5] = 8'h02; tm[5] = 1'b1;

    // Reset with both requesters asserting: nothing may be offered.
    rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_m = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({req_ready, rsp_valid, obs_rsp, busy}), 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Directed single-requester arithmetic.
    single_op(1'b0, 8'h05, 8'h03, 1'b0, "add_5_3");
    single_op(1'b1, 8'h7F, 8'h01, 1'b0, "add_ovf");
    single_op(1'b0, 8'h10, 8'h10, 1'b1, "sub_zero");
    single_op(1'b0, 8'h00, 8'h01, 1'b1, "sub_borrow");
    single_op(1'b1, 8'h80, 8'h80, 1'b0, "add_neg_ovf");

    // Both requesters continuously valid: grants must alternate 0,1,0,1.
    @(negedge clk);
    cur[0] = 0; cur[1] = 1; grants = 0; resps = 0; n = 0; pend = -1;
    set_op(1'b0, ta[0], tb_[0], tm[0]);
    set_op(1'b1, ta[1], tb_[1], tm[1]);
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    while (resps < 4 && n < 60) begin
      if (req_ready != 2'b00) begin
        chk("tie_grant", 32'(req_ready), (grants % 2) ? 32'd2 : 32'd1);
        r = req_ready[1];
        sb_q.push_back(model_rsp(r, ta[cur[r]], tb_[cur[r]], tm[cur[r]]));
        cur[r] += 2;
        pend = int'(r);
        grants++;
      end
      if (busy) chk("tie_busy_noready", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        pop_cmp("tie_rsp");
        resps++;
      end
      @(negedge clk);
      n++;
      if (pend >= 0) begin
        if (grants >= 4) req_valid = 2'b00;
        else set_op(pend[0], ta[cur[pend]], tb_[cur[pend]], tm[cur[pend]]);
        pend = -1;
      end
      #1;
    end
    chk("tie_resp_count", 32'(resps), 32'd4);

    // Backpressure in RESP with a competing request waiting.
    @(negedge clk);
    set_op(1'b0, 8'hC8, 8'h64, 1'b1);
    set_op(1'b1, 8'h21, 8'h12, 1'b0);
    req_valid = 2'b11; rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'd1);
    sb_q.push_back(model_rsp(1'b0, 8'hC8, 8'h64, 1'b1));
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("bp_exec_noready", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 32'({rsp_valid, obs_rsp}), 32'({1'b1, sb_q[0]}));
      chk("bp_noready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    held = sb_q[0];
    pop_cmp("bp_rsp");
    @(negedge clk);
    chk("bp_released", 32'({busy, rsp_valid}), 32'd0);
    chk("bp_rsp_kept", 32'(obs_rsp), 32'(held));
    chk("bp_next_grant", 32'(req_ready), 32'd2);
    sb_q.push_back(model_rsp(1'b1, 8'h21, 8'h12, 1'b0));
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    pop_cmp("bp_next");
    @(negedge clk);

    // Reset during EXEC aborts the operation.
    set_op(1'b0, 8'h11, 8'h22, 1'b0);
    req_valid = 2'b01;
    #1;
    wait_ready(1'b0, "abort");
    @(negedge clk);
    chk("abort_in_exec", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({req_ready, rsp_valid, obs_rsp, busy}), 32'd0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'({busy, rsp_valid}), 32'd0);
    end
    set_op(1'b0, 8'h40, 8'h41, 1'b1);
    set_op(1'b1, 8'h09, 8'h09, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("post_reset_tie", 32'(req_ready), 32'd1);
    sb_q.push_back(model_rsp(1'b0, 8'h40, 8'h41, 1'b1));
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    pop_cmp("post_reset_rsp");
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addsub_arb.md
Name: addsub_arb

Overview:
- Two-requester round-robin arbiter and sequencer that shares one 8-bit `addsub` datapath (A ± B with C/V/N/Z flags).
- Captures the granted requester's operands into registers and drives them into the single `addsub` instance. Registers the sum and flags, then returns them tagged with the requester ID over a valid/ready response channel.
- Sits between the two ALU clients and the shared arithmetic unit.

Parameters:
- NREQ, 2, number of requesters; fixed at 2, only this value is supported.
- W, 8, operand width; must match `addsub` (8).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: requester i's operation is accepted this cycle.
- req_a  input  16  operand A; [7:0]=req0, [15:8]=req1.
- req_b  input  16  operand B; same packing.
- req_m  input  2  mode per requester: 0=add, 1=subtract (A−B).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that issued the result.
- rsp_s  output  8  sum/difference.
- rsp_c, rsp_v, rsp_n, rsp_z  output  1 each  carry, signed overflow, negative, zero flags from `addsub`.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, last_grant=1 (so req0 wins the first tie).
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_s=0, all flags 0, busy=0.
  - Operand registers are cleared to 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is decided combinationally.
    - Only one req_valid bit set: that requester is granted.
    - Both set: the requester ≠ last_grant is granted.
    - None set: no grant.
  - req_ready[g]=1 only for the granted g, and only in IDLE.
  - On a handshake (req_valid[g] & req_ready[g]):
    - Latch a_r, b_r, m_r, id_r=g; set last_grant=g.
    - Go to EXEC.
- EXEC:
  - a_r, b_r, m_r drive `addsub`.
  - At the clock edge, capture S, C, V, N, Z and id_r into the rsp_* registers; set rsp_valid=1; go to RESP.
  - Stays exactly one cycle.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid→0 at the next edge; state→IDLE.
  - The rsp_* data registers keep their last value; only rsp_valid is cleared.
- Latency and throughput:
  - Handshake at edge t gives rsp_valid=1 after edge t+1 (visible in cycle t+1).
  - The next request is accepted in IDLE at the earliest in cycle t+3 (rsp_ready tied high).
  - At most one operation in flight.
- Requester rules:
  - A requester must hold req_valid and operands stable until its req_ready; the arbiter never drops a granted request.
  - req_ready is 0 in EXEC and RESP, even if req_valid is high.
- Arithmetic: as defined by `addsub`.
  - Subtract: S = A + ~B + 1 (mod 256).
  - C = carry out of bit 7 (for subtract: 1 = no borrow).
  - V = carry into bit 7 XOR carry out of bit 7.
  - N = S[7]; Z = (S==0).
- Boundaries:
  - Simultaneous requests with continuous valid strictly alternate 0,1,0,1.
  - req_valid deasserted by a non-granted requester has no effect.
  - rsp_ready high in RESP on the same cycle that new req_valid arrives: the new request waits for IDLE (no bypass).
  - rst_n asserted mid-EXEC or mid-RESP aborts the operation immediately; no response is ever emitted for it.
  - Reset deassertion resumes in IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2 (2'd3 illegal → IDLE).
  - W=8.
  - Requester ID width (1).
- One sub-module: the existing `addsub`, instantiated once, with inputs driven from the operand registers.
- Arbitration logic is small and stays inline.

Test Plan:
- Reset then req0 only, A=0x05, B=0x03, M=0.
  - req_ready[0] high one cycle; two cycles later rsp_valid=1, id=0, S=0x08, C=0, V=0, N=0, Z=0.
- req1 only, A=0x7F, B=0x01, M=0.
  - S=0x80, V=1, N=1, C=0, Z=0, id=1.
- req0 only, A=0x10, B=0x10, M=1.
  - S=0x00, Z=1, C=1, V=0, N=0.
  - Then A=0x00, B=0x01, M=1 → S=0xFF, C=0, N=1, V=0.
- Both valid continuously for 4 operations with rsp_ready=1.
  - Grants go 0,1,0,1; rsp_id follows the same order.
  - req_ready is never high in EXEC or RESP.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_* stable throughout; req_ready stays 0 with req_valid high.
  - Release: rsp_valid drops after one edge; the next grant follows in IDLE.
- Drop rst_n during EXEC.
  - All outputs 0 immediately (asynchronous).
  - After release, state is IDLE; no rsp_valid for the aborted operation.
  - The next tie grants req0.
